// File: rtl/tau_drain.sv
// Buffers (word_0, word_1) pairs in a DEPTH-deep FIFO and serialises each pair as two out beats.
// First word appears the cycle after a push into an empty FIFO; in_ready drops only when full.
module tau_drain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word_0,
  input  logic [WIDTH-1:0] in_word_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             flush,
  output logic [WIDTH-1:0] checksum,
  output logic [CNT_W-1:0] pair_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] W0   = 2'd1;
  localparam logic [1:0] W1   = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] word_0;
    logic [WIDTH-1:0] word_1;
  } pair_t;

  pair_t            mem_q [DEPTH];
  pair_t            wr_pair_d;
  pair_t            head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] checksum_q, checksum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == W1) && out_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_pair_d        = '0;
    wr_pair_d.word_0 = in_word_0;
    wr_pair_d.word_1 = in_word_1;
    wr_ptr_d         = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d         = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push) state_d = W0;
      W0:      if (out_ready) state_d = W1;
      W1:      if (out_ready) state_d = (wr_ptr_d != rd_ptr_d) ? W0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A coincident flush overrides the pop-time update.
  always_comb begin
    checksum_d = checksum_q;
    count_d    = count_q;
    if (pop) begin
      checksum_d = checksum_q ^ head.word_0 ^ head.word_1;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end
    if (flush) begin
      checksum_d = '0;
      count_d    = '0;
    end
  end

  always_comb begin
    out_valid = (state_q != IDLE);
    out_last  = (state_q == W1);
    out_data  = '0;
    if (state_q == W0) out_data = head.word_0;
    if (state_q == W1) out_data = head.word_1;
  end

  assign checksum   = checksum_q;
  assign pair_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      checksum_q <= '0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      checksum_q <= checksum_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: out_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_pair_d;
  end

endmodule

// File: tb/tb_tau_drain.sv
// Directed and randomised bench for tau_drain against a queue-based pair model.
module tb_tau_drain;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_word_0;
  logic [WIDTH-1:0] in_word_1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             flush;
  logic [WIDTH-1:0] checksum;
  logic [CNT_W-1:0] pair_count;

  tau_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word_0  (in_word_0),
    .in_word_1  (in_word_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush      (flush),
    .checksum   (checksum),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of pending pairs, which half of the head is on the wire,
  // running checksum and saturating count.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit               m_phase;
  logic [WIDTH-1:0] m_cs;
  int               m_cnt;
  bit               m_last_push;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_phase     = 1'b0;
    m_cs        = '0;
    m_cnt       = 0;
    m_last_push = 1'b0;
  endtask

  task automatic check_outputs();
    bit               ne;
    logic [WIDTH-1:0] exp_data;
    ne       = (q0.size() != 0);
    exp_data = '0;
    if (ne) exp_data = m_phase ? q1[0] : q0[0];
    chk("in_ready",   WIDTH'(in_ready),   WIDTH'(q0.size() < DEPTH));
    chk("out_valid",  WIDTH'(out_valid),  WIDTH'(ne));
    chk("out_last",   WIDTH'(out_last),   WIDTH'(ne && m_phase));
    chk("out_data",   out_data,           exp_data);
    chk("checksum",   checksum,           m_cs);
    chk("pair_count", WIDTH'(pair_count), WIDTH'(m_cnt));
  endtask

  task automatic model_edge();
    bit ne;
    bit do_push;
    ne      = (q0.size() != 0);
    do_push = in_valid && (q0.size() < DEPTH);
    if (ne && out_ready) begin
      if (!m_phase) begin
        m_phase = 1'b1;
      end else begin
        m_cs = m_cs ^ q0[0] ^ q1[0];
        if (m_cnt < CNT_MAX) m_cnt++;
        void'(q0.pop_front());
        void'(q1.pop_front());
        m_phase = 1'b0;
      end
    end
    if (flush) begin
      m_cs  = '0;
      m_cnt = 0;
    end
    if (do_push) begin
      q0.push_back(in_word_0);
      q1.push_back(in_word_1);
    end
    m_last_push = do_push;
  endtask

  // Drive one cycle's inputs, check outputs at the falling edge, advance the model
  // across the rising edge, and return just after it.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_word_0 = a;
    in_word_1 = b;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] w0;
    logic [WIDTH-1:0] w1;
    logic             v;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word_0 = '0;
    in_word_1 = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();
    #1;
    chk("rst_in_ready",  WIDTH'(in_ready),   '0);
    chk("rst_out_valid", WIDTH'(out_valid),  '0);
    chk("rst_out_last",  WIDTH'(out_last),   '0);
    chk("rst_out_data",  out_data,           '0);
    chk("rst_checksum",  checksum,           '0);
    chk("rst_count",     WIDTH'(pair_count), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pair through with downstream always ready.
    cycle(1'b1, 32'hA, 32'hB, 1'b1, 1'b0);
    chk("t1_word0", out_data, 32'hA);
    chk("t1_last0", WIDTH'(out_last), '0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t1_word1", out_data, 32'hB);
    chk("t1_last1", WIDTH'(out_last), 32'h1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t1_checksum", checksum, 32'h1);
    chk("t1_count", WIDTH'(pair_count), 32'h1);

    // Fill with downstream stalled; a fifth pair waits until a pop has happened.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + i, 32'h200 + i, 1'b0, 1'b0);
    chk("t2_full", WIDTH'(in_ready), '0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h104, 32'h204, (i >= 2), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall in W1 for three cycles.
    cycle(1'b1, 32'hC0DE0, 32'hC0DE1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t3_data",  out_data, 32'hC0DE1);
      chk("t3_last",  WIDTH'(out_last),  32'h1);
      chk("t3_valid", WIDTH'(out_valid), 32'h1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Push every cycle with downstream ready: fills, then wraps many times.
    w0 = $urandom;
    w1 = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (i > 0 && m_last_push) begin
        w0 = $urandom;
        w1 = $urandom;
      end
      cycle(1'b1, w0, w1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_count_sat", WIDTH'(pair_count), WIDTH'(CNT_MAX));

    // Flush coincident with a W1 pop, then a fresh pair.
    cycle(1'b1, 32'h11, 32'h22, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    chk("t5_flush_cs",  checksum, '0);
    chk("t5_flush_cnt", WIDTH'(pair_count), '0);
    cycle(1'b1, 32'h3, 32'h5, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t5_checksum", checksum, 32'h6);

    // Reset while in W1 with three pairs buffered.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + i, 32'h400 + i, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_pre_last", WIDTH'(out_last), 32'h1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",    WIDTH'(out_valid),  '0);
    chk("t6_rst_in_ready", WIDTH'(in_ready),   '0);
    chk("t6_rst_data",     out_data,           '0);
    chk("t6_rst_cs",       checksum,           '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_in_ready", WIDTH'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomised traffic, holding an offered pair until it is taken.
    v  = 1'b0;
    w0 = '0;
    w1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!v || m_last_push) begin
        v  = ($urandom_range(0, 9) < 7);
        w0 = $urandom;
        w1 = $urandom;
      end
      cycle(v, w0, w1, ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 2));
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
